// File: rtl/rand_num_gen_63.sv
// 6-bit Fibonacci LFSR (x^6 + x^5 + 1), period 63, used to pick random grid cells.
// The state register powers up at 6'b000001 so the block runs without ever seeing reset.
module rand_num_gen_63 (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] seed,
  output logic [5:0] rnd
);

  logic [5:0] s_q = 6'b000001;
  logic [5:0] s_d;

  // Feedback bit: taps at bits 5 and 4, entering at bit 0 after a left shift.
  function automatic logic [5:0] lfsr_step(input logic [5:0] cur);
    lfsr_step = {cur[4:0], cur[5] ^ cur[4]};
  endfunction

  // Next-state selection: reload from seed under reset, escape the all-zero lockup, else step.
  always_comb begin
    s_d = s_q;
    if (!reset) begin
      if (seed == 6'b000000) begin
        s_d = 6'b000001;
      end else begin
        s_d = seed;
      end
    end else if (s_q == 6'b000000) begin
      s_d = 6'b000001;
    end else begin
      s_d = lfsr_step(s_q);
    end
  end

  // State register; reset is folded into s_d so it acts synchronously.
  always_ff @(posedge clk) begin
    s_q <= s_d;
  end

  assign rnd = s_q;

endmodule

// File: tb/tb_rand_num_gen_63.sv
// Directed bench for rand_num_gen_63: power-up, seeded reset, zero seed, period and mid-run reset.
module tb_rand_num_gen_63;

  logic       clk;
  logic       reset;
  logic [5:0] seed;
  logic [5:0] rnd;

  int tests_run    = 0;
  int tests_failed = 0;

  rand_num_gen_63 dut (
    .clk   (clk),
    .reset (reset),
    .seed  (seed),
    .rnd   (rnd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [5:0] got, input logic [5:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one edge and sample away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference next-state for the period walk.
  function automatic logic [5:0] ref_next(input logic [5:0] cur);
    ref_next = {cur[4:0], cur[5] ^ cur[4]};
  endfunction

  task automatic load_seed(input logic [5:0] s);
    reset = 1'b0;
    seed  = s;
    step();
    reset = 1'b1;
  endtask

  logic [5:0] exp_a [0:4] = '{6'd13, 6'd26, 6'd53, 6'd42, 6'd21};
  logic [5:0] exp_b [0:3] = '{6'd19, 6'd39, 6'd15, 6'd30};
  logic [5:0] exp_z [0:4] = '{6'd2, 6'd4, 6'd8, 6'd16, 6'd33};

  initial begin
    reset = 1'b1;
    seed  = 6'd0;
    #1;
    // Power-up without any reset: starts at 1 and steps normally.
    check_val("powerup_init", rnd, 6'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("powerup_step", rnd, exp_z[i]);
    end
    // Seed changes while not in reset are ignored.
    seed = 6'd55;
    step();
    check_val("seed_ignored0", rnd, 6'd16);
    seed = 6'd9;
    step();
    check_val("seed_ignored1", rnd, 6'd33);

    load_seed(6'd38);
    check_val("seed38_load", rnd, 6'd38);
    for (int i = 0; i < 5; i++) begin
      step();
      check_val("seed38_seq", rnd, exp_a[i]);
    end

    load_seed(6'd41);
    check_val("seed41_load", rnd, 6'd41);
    for (int i = 0; i < 4; i++) begin
      step();
      check_val("seed41_seq", rnd, exp_b[i]);
    end

    load_seed(6'd0);
    check_val("seed0_load", rnd, 6'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      check_val("seed0_seq", rnd, exp_z[i]);
    end

    // Full period from 38: every value distinct, nonzero, and back to 38 at step 63.
    begin
      logic [63:0] seen;
      logic [5:0]  model;
      logic        ok;
      load_seed(6'd38);
      seen  = 64'd0;
      model = 6'd38;
      ok    = 1'b1;
      for (int i = 0; i < 63; i++) begin
        step();
        model = ref_next(model);
        check_val("period_step", rnd, model);
        if (rnd == 6'd0 || seen[rnd]) ok = 1'b0;
        seen[rnd] = 1'b1;
      end
      check_val("period_return", rnd, 6'd38);
      check_val("period_distinct", {5'd0, ok}, 6'd1);
    end

    // Mid-run reset: 10 steps from 38 reach 63, then a 2-edge reset with seed 41.
    load_seed(6'd38);
    for (int i = 0; i < 10; i++) step();
    check_val("midrun_before", rnd, 6'd63);
    reset = 1'b0;
    seed  = 6'd41;
    step();
    check_val("midrun_rst1", rnd, 6'd41);
    step();
    check_val("midrun_rst2", rnd, 6'd41);
    reset = 1'b1;
    step();
    check_val("midrun_resume", rnd, 6'd19);

    // Seed tracked while reset is held: the last sampled seed wins.
    reset = 1'b0;
    seed  = 6'd5;
    step();
    check_val("track_seed0", rnd, 6'd5);
    seed = 6'd21;
    step();
    check_val("track_seed1", rnd, 6'd21);
    reset = 1'b1;
    step();
    check_val("track_step", rnd, 6'd43);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
